// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with its sequencer: loads A/B/Cin on Start, shifts WIDTH cycles LSB-first,
// then publishes {Cout,Sum} with a one-cycle Done pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int unsigned CntW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CntW-1:0]  r_cnt;

    logic w_s;
    logic w_c;

    // 1-bit full adder on the operand LSBs and the carry flip-flop
    assign w_s = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_c     <= i_cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_c   <= w_c;
                    r_s   <= {w_s, r_s[WIDTH-1:1]};
                    r_cnt <= r_cnt + CntW'(1);
                    // Final shift: publish the completed word, including this cycle's bit
                    if (r_cnt == LastCnt) begin
                        r_sum   <= {w_s, r_s[WIDTH-1:1]};
                        r_cout  <= w_c;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus random operands checked
// against plain integer addition.
`timescale 1ns / 1ps
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    always #5 clk = ~clk;

    // Launch one operation, scramble the input pins after acceptance, and observe W+4 cycles.
    // lat is the number of negedges after the accepting edge at which Done is first seen.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          output logic [W-1:0] rs, output logic rc, output int lat,
                          output int busy_n, output int done_n);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = -1; busy_n = 0; done_n = 0; rs = sum; rc = cout;
        for (int k = 0; k < W + 4; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
                rs = sum; rc = cout;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic chk_busy);
        logic [W-1:0] rs;
        logic         rc;
        int           lat, busy_n, done_n;
        logic [W:0]   exp;
        exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        run_op(ta, tb_, tc, rs, rc, lat, busy_n, done_n);
        checks++;
        if ({rc, rs} !== exp) begin
            failures++;
            $display("FAIL %s result a=%h b=%h cin=%0d got cout=%0d sum=%h expected cout=%0d sum=%h",
                     name, ta, tb_, tc, rc, rs, exp[W], exp[W-1:0]);
        end
        checks++;
        if (lat !== W || done_n !== 1) begin
            failures++;
            $display("FAIL %s done_timing got lat=%0d pulses=%0d expected lat=%0d pulses=1",
                     name, lat, done_n, W);
        end
        if (chk_busy) begin
            checks++;
            if (busy_n !== W + 1) begin
                failures++;
                $display("FAIL %s busy_cycles got %0d expected %0d", name, busy_n, W + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_held got busy=%0d done=%0d cout=%0d sum=%h expected all 0",
                     busy, done, cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL reset_release got busy=%0d done=%0d cout=%0d sum=%h expected all 0",
                     busy, done, cout, sum);
        end
    endtask

    task automatic test_basic();
        check_op("basic_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b1);
    endtask

    task automatic test_carry();
        check_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1);
        check_op("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        int           done_n = 0;
        int           lat = -1;
        logic [W-1:0] rs;
        logic         rc;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rs = sum; rc = cout;
        for (int k = 0; k < 3 * W; k++) begin
            if (k == 2) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
                rs = sum; rc = cout;
            end
            @(negedge clk);
        end
        checks++;
        if (done_n !== 1 || lat !== W) begin
            failures++;
            $display("FAIL ignore_start pulses got %0d lat=%0d expected 1 lat=%0d", done_n, lat, W);
        end
        checks++;
        if ({rc, rs} !== {1'b0, 8'h30} || sum !== 8'h30) begin
            failures++;
            $display("FAIL ignore_start result got cout=%0d sum=%h held=%h expected 0 30 30",
                     rc, rs, sum);
        end
    endtask

    task automatic test_abort();
        int seen_done = 0;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            if (done) seen_done++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            failures++;
            $display("FAIL abort_reset got busy=%0d done=%0d cout=%0d sum=%h expected all 0",
                     busy, done, cout, sum);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got pulses=%0d busy=%0d expected 0 0", seen_done, busy);
        end
        check_op("after_abort_7f_01", 8'h7F, 8'h01, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int idx[$];
        int bad_sum = 0;
        int bad_gap = 0;
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 55; k++) begin
            @(negedge clk);
            if (done) begin
                idx.push_back(k);
                if (sum !== 8'h03 || cout !== 1'b0) bad_sum++;
            end
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        for (int i = 1; i < idx.size(); i++)
            if (idx[i] - idx[i-1] != W + 2) bad_gap++;
        checks++;
        if (idx.size() < 5 || bad_gap != 0) begin
            failures++;
            $display("FAIL back_to_back spacing got pulses=%0d bad_gaps=%0d expected >=5 pulses 0 bad",
                     idx.size(), bad_gap);
        end
        checks++;
        if (bad_sum != 0) begin
            failures++;
            $display("FAIL back_to_back result got %0d wrong sums expected 0", bad_sum);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] held;
        for (int i = 0; i < 16; i++)
            check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        held = sum;
        a = W'($urandom); b = W'($urandom);
        repeat (5) @(negedge clk);
        checks++;
        if (sum !== held || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got sum=%h busy=%0d expected sum=%h busy=0", sum, busy, held);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
